io_bus_decoder: RTL and testbench

//  Parametrised successor to the fixed nano6502 address decoder. Decodes the 6502 bus

---
 rtl/nano6502_bus_pkg.sv | 23 ++
 rtl/bus_wait_gen.sv | 79 +++++++
 rtl/io_bus_decoder.sv | 154 +++++++++++++++
 tb/tb_io_bus_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nano6502_bus_pkg.sv
// Shared constants and types for the nano6502 bus decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nano6502_bus_pkg;

    // Address map
    localparam logic [7:0]  IO_PAGE     = 8'hFE;     // banked device window
    localparam logic [7:0]  VEC_PAGE    = 8'hFF;     // vectors, always ROM
    localparam logic [15:0] ROM_LO      = 16'hE000;  // start of ROM overlay

    // Control register addresses (shadow RAM in zero page)
    localparam logic [15:0] REG_BANK_LO = 16'h0000;
    localparam logic [15:0] REG_BANK_HI = 16'h0001;
    localparam logic [15:0] REG_ROM_SEL = 16'h0002;

    // Wait-state generator states
    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        WAIT_WAIT = 2'd1,
        WAIT_DONE = 2'd2
    } wait_state_t;

endpackage

// File: rtl/bus_wait_gen.sv
// Per-access wait-state generator: stalls the CPU for a programmed number of cycles.
// Latency: rdy drops combinationally on start; access completes W+1 cycles after start.
// Backpressure: o_rdy low stalls the CPU; an address/direction change mid-stall aborts.
//
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   i_wait_cnt      stall length W for the access presented this cycle
//   i_start         a waited access is presented (only sampled in IDLE)
//   i_abort         CPU changed address or direction since last cycle
//   o_rdy           to CPU Rdy
module bus_wait_gen
    import nano6502_bus_pkg::*;
#(
    parameter int WAIT_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_rdy
);

    wait_state_t       r_state;
    wait_state_t       w_state_nxt;
    logic [WAIT_W-1:0] r_cnt;
    logic [WAIT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= WAIT_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The IDLE cycle that detects the access already counts as the first
    // stall cycle, so r_cnt holds the stall cycles still to come while in
    // WAIT (W-1 down to 1). The last WAIT cycle leaves the counter at zero
    // and hands over to DONE, giving exactly W low cycles in total.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_rdy       = 1'b1;
        case (r_state)
            WAIT_IDLE: begin
                if (i_start) begin
                    o_rdy       = 1'b0;
                    w_cnt_nxt   = i_wait_cnt - 1'b1;
                    w_state_nxt = (i_wait_cnt == WAIT_W'(1)) ? WAIT_DONE : WAIT_WAIT;
                end
            end
            WAIT_WAIT: begin
                o_rdy = 1'b0;
                if (i_abort) begin
                    // CPU moved on; re-evaluate the new access from IDLE
                    w_state_nxt = WAIT_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == WAIT_W'(1)) begin
                        w_state_nxt = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // Access completes this cycle
                w_state_nxt = WAIT_IDLE;
            end
            default: begin
                w_state_nxt = WAIT_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/io_bus_decoder.sv
// 6502 bus decoder: RAM/ROM/banked-IO selects, bank and ROM-overlay registers, read mux.
// Latency: decode and read mux are combinational; register writes land on the next clock.
// Backpressure: per-device wait states stall the CPU through rdy_o; RAM/ROM/registers never wait.
//
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   R_W_n, addr_i, data_i   CPU bus (1 = read)
//   data_o, rdy_o           read data and Rdy back to the CPU
//   ram_cs, rom_cs, dev_cs  memory and one-hot device selects
//   ram_data_i, rom_data_i  memory read data
//   dev_data_i              device read data, device k at [k*8 +: 8]
//   bank_o                  current IO bank
module io_bus_decoder
    import nano6502_bus_pkg::*;
#(
    parameter int                        NUM_DEV  = 8,
    parameter int                        WAIT_W   = 3,
    parameter logic [NUM_DEV*WAIT_W-1:0] WAIT_TBL = '0,
    parameter logic [7:0]                OPEN_BUS = 8'hFF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 R_W_n,
    input  logic [15:0]          addr_i,
    input  logic [7:0]           data_i,
    output logic [7:0]           data_o,
    output logic                 rdy_o,
    output logic                 ram_cs,
    output logic                 rom_cs,
    output logic [NUM_DEV-1:0]   dev_cs,
    input  logic [7:0]           ram_data_i,
    input  logic [7:0]           rom_data_i,
    input  logic [8*NUM_DEV-1:0] dev_data_i,
    output logic [15:0]          bank_o
);

    localparam logic [15:0] DEV_LIM = 16'(NUM_DEV);

    logic [15:0]       r_bank;
    logic [7:0]        r_rom_sel;
    logic [15:0]       r_addr_q;
    logic              r_rw_q;

    logic              w_reg_hit;
    logic              w_dev_vld;
    logic [7:0]        w_dev_rdata;
    logic [WAIT_W-1:0] w_dev_wait;
    logic              w_start;
    logic              w_abort;
    logic              w_wait_rdy;
    logic              w_wr_en;

    // Address decode, first match wins
    always_comb begin
        ram_cs    = 1'b0;
        rom_cs    = 1'b0;
        w_reg_hit = 1'b0;
        w_dev_vld = 1'b0;
        if (addr_i <= REG_ROM_SEL) begin
            w_reg_hit = 1'b1;
        end else if (addr_i[15:8] == VEC_PAGE) begin
            rom_cs = 1'b1;
        end else if (addr_i[15:8] == IO_PAGE) begin
            w_dev_vld = (r_bank < DEV_LIM);
        end else if (addr_i >= ROM_LO) begin
            if (r_rom_sel[0]) begin
                ram_cs = 1'b1;
            end else begin
                rom_cs = 1'b1;
            end
        end else begin
            ram_cs = 1'b1;
        end
    end

    // Device select, read data and wait count for the current bank
    always_comb begin
        dev_cs      = '0;
        w_dev_rdata = '0;
        w_dev_wait  = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (w_dev_vld && (r_bank == 16'(k))) begin
                dev_cs[k]   = 1'b1;
                w_dev_rdata = dev_data_i[k*8 +: 8];
                w_dev_wait  = WAIT_TBL[k*WAIT_W +: WAIT_W];
            end
        end
    end

    // Read mux; writes drive zero
    always_comb begin
        data_o = 8'h00;
        if (R_W_n) begin
            if (w_reg_hit) begin
                case (addr_i[1:0])
                    2'd0:    data_o = r_bank[7:0];
                    2'd1:    data_o = r_bank[15:8];
                    default: data_o = r_rom_sel;
                endcase
            end else if (ram_cs) begin
                data_o = ram_data_i;
            end else if (rom_cs) begin
                data_o = rom_data_i;
            end else if (w_dev_vld) begin
                data_o = w_dev_rdata;
            end else begin
                data_o = OPEN_BUS;
            end
        end
    end

    assign w_wr_en = !R_W_n && rdy_o && w_reg_hit;

    // Previous-cycle bus lets the wait generator spot the CPU moving on
    assign w_abort = (addr_i != r_addr_q) || (R_W_n != r_rw_q);
    assign w_start = w_dev_vld && (w_dev_wait != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bank    <= '0;
            r_rom_sel <= '0;
            r_addr_q  <= '0;
            r_rw_q    <= 1'b1;
        end else begin
            r_addr_q <= addr_i;
            r_rw_q   <= R_W_n;
            if (w_wr_en) begin
                case (addr_i)
                    REG_BANK_LO: r_bank[7:0]  <= data_i;
                    REG_BANK_HI: r_bank[15:8] <= data_i;
                    REG_ROM_SEL: r_rom_sel    <= data_i;
                    default: ;
                endcase
            end
        end
    end

    bus_wait_gen #(
        .WAIT_W (WAIT_W)
    ) u_wait (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .i_wait_cnt (w_dev_wait),
        .i_start    (w_start),
        .i_abort    (w_abort),
        .o_rdy      (w_wait_rdy)
    );

    // While reset is held the CPU must see Rdy high even if a waited
    // device is being addressed, so reset overrides the IDLE start stall.
    assign rdy_o  = w_wait_rdy | ~rst_n_i;
    assign bank_o = r_bank;

endmodule

// File: tb/tb_io_bus_decoder.sv
module tb_io_bus_decoder;

    logic        clk;
    logic        rst_n;
    logic        r_w_n;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  data_o;
    logic        rdy;
    logic        ram_cs;
    logic        rom_cs;
    logic [7:0]  dev_cs;
    logic [7:0]  ram_d;
    logic [7:0]  rom_d;
    logic [63:0] dev_d;
    logic [15:0] bank_o;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [15:0] m_bank;
    logic [7:0]  m_rom_sel;
    int          wtab [8] = '{0, 0, 3, 0, 2, 7, 0, 1};

    io_bus_decoder #(
        .NUM_DEV  (8),
        .WAIT_W   (3),
        .WAIT_TBL ({3'd1, 3'd0, 3'd7, 3'd2, 3'd0, 3'd3, 3'd0, 3'd0}),
        .OPEN_BUS (8'hFF)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .R_W_n      (r_w_n),
        .addr_i     (addr),
        .data_i     (wdata),
        .data_o     (data_o),
        .rdy_o      (rdy),
        .ram_cs     (ram_cs),
        .rom_cs     (rom_cs),
        .dev_cs     (dev_cs),
        .ram_data_i (ram_d),
        .rom_data_i (rom_d),
        .dev_data_i (dev_d),
        .bank_o     (bank_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Expected {ram_cs, rom_cs, dev_cs[7:0]}
    function automatic logic [9:0] m_sel(input logic [15:0] a);
        if (a <= 16'h0002) return 10'd0;
        if (a >= 16'hFF00) return 10'b01_0000_0000;
        if (a >= 16'hFE00) return (m_bank < 16'd8) ? {2'b00, 8'(1 << m_bank)} : 10'd0;
        if (a >= 16'hE000) return m_rom_sel[0] ? 10'b10_0000_0000 : 10'b01_0000_0000;
        return 10'b10_0000_0000;
    endfunction

    function automatic logic [7:0] m_rdata(input logic [15:0] a);
        if (a == 16'h0000) return m_bank[7:0];
        if (a == 16'h0001) return m_bank[15:8];
        if (a == 16'h0002) return m_rom_sel;
        if (a >= 16'hFF00) return rom_d;
        if (a >= 16'hFE00) return (m_bank < 16'd8) ? dev_d[m_bank[2:0]*8 +: 8] : 8'hFF;
        if (a >= 16'hE000) return m_rom_sel[0] ? ram_d : rom_d;
        return ram_d;
    endfunction

    function automatic int m_wait(input logic [15:0] a);
        if (a >= 16'hFE00 && a < 16'hFF00 && m_bank < 16'd8) return wtab[m_bank[2:0]];
        return 0;
    endfunction

    // One complete CPU access. Call just after a rising edge; returns on the
    // rising edge that completes the access.
    task automatic access(input logic rw, input logic [15:0] a, input logic [7:0] wd);
        int         stall;
        int         ew;
        logic [9:0] es;
        logic [7:0] ed;
        #1;
        r_w_n = rw;
        addr  = a;
        wdata = wd;
        ram_d = 8'($urandom);
        rom_d = 8'($urandom);
        dev_d = {$urandom, $urandom};
        es = m_sel(a);
        ed = rw ? m_rdata(a) : 8'h00;
        ew = m_wait(a);
        stall = 0;
        @(negedge clk);
        while (rdy !== 1'b1 && stall < 20) begin
            stall++;
            @(negedge clk);
        end
        chk($sformatf("stall@%h", a), stall, ew);
        chk($sformatf("sel@%h", a), {ram_cs, rom_cs, dev_cs}, es);
        chk($sformatf("data@%h", a), data_o, ed);
        chk("bank_o", bank_o, m_bank);
        @(posedge clk);
        if (!rw) begin
            if (a == 16'h0000) m_bank[7:0] = wd;
            else if (a == 16'h0001) m_bank[15:8] = wd;
            else if (a == 16'h0002) m_rom_sel = wd;
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  wd;
        logic        rw;

        rst_n = 1'b0;
        r_w_n = 1'b1;
        addr  = 16'h0000;
        wdata = 8'h00;
        ram_d = 8'h00;
        rom_d = 8'h00;
        dev_d = '0;
        m_bank    = 16'h0000;
        m_rom_sel = 8'h00;

        #12;
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_bank", bank_o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // ROM overlay control
        access(1'b1, 16'h0002, 8'h00);
        access(1'b1, 16'hE010, 8'h00);
        access(1'b0, 16'h0002, 8'h01);
        access(1'b1, 16'hE010, 8'h00);

        // Banked device and vector page
        access(1'b0, 16'h0000, 8'h03);
        access(1'b1, 16'hFE05, 8'h00);
        access(1'b1, 16'hFF00, 8'h00);

        // Unmapped bank
        access(1'b0, 16'h0000, 8'h09);
        access(1'b1, 16'hFE00, 8'h00);

        // Waited device, back to back
        access(1'b0, 16'h0000, 8'h02);
        access(1'b1, 16'hFE10, 8'h00);
        access(1'b1, 16'hFE10, 8'h00);

        // Reset in the middle of a stall
        #1;
        r_w_n = 1'b1;
        addr  = 16'hFE10;
        @(negedge clk);
        chk("pre_rst_stall", rdy, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rdy", rdy, 1'b1);
        chk("midrst_bank", bank_o, 16'h0000);
        m_bank    = 16'h0000;
        m_rom_sel = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        access(1'b1, 16'hFE00, 8'h00);
        access(1'b1, 16'h0002, 8'h00);

        // Abort a stall by moving to RAM
        access(1'b0, 16'h0000, 8'h02);
        #1;
        r_w_n = 1'b1;
        addr  = 16'hFE10;
        @(negedge clk);
        chk("abort_stall", rdy, 1'b0);
        @(posedge clk);
        #1;
        addr  = 16'h1234;
        ram_d = 8'($urandom);
        @(negedge clk);
        chk("abort_sel", {ram_cs, rom_cs, dev_cs}, 10'b10_0000_0000);
        @(negedge clk);
        chk("abort_rdy", rdy, 1'b1);
        chk("abort_data", data_o, ram_d);
        @(posedge clk);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0:       a = 16'($urandom_range(0, 2));
                1:       a = 16'($urandom_range(16'h0003, 16'hDFFF));
                2:       a = 16'($urandom_range(16'hE000, 16'hFDFF));
                3, 4:    a = 16'hFE00 | 16'($urandom_range(0, 255));
                default: a = 16'hFF00 | 16'($urandom_range(0, 255));
            endcase
            rw = ($urandom_range(0, 3) != 0);
            if (a == 16'h0000)      wd = 8'($urandom_range(0, 10));
            else if (a == 16'h0001) wd = ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00;
            else                    wd = 8'($urandom);
            access(rw, a, wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
